phase_step_ctrl: RTL and testbench

PHASE_STEP_CTRL -- requirements
Module: phase_step_ctrl

---
 rtl/phase_step_ctrl.sv | 91 +++++++++
 tb/tb_phase_step_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/phase_step_ctrl.sv
// Prescaled strobe generator that ramps a counter increment one LSB per strobe
// toward a requested target, so the downstream counter never sees a rate jump.
module phase_step_ctrl #(
    parameter int WIDTH     = 9,
    parameter int DIV_WIDTH = 16,
    parameter int INIT_INCR = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic                 step_valid,
    input  logic [WIDTH-1:0]     step_data,
    output logic                 step_ready,
    output logic                 en,
    output logic [WIDTH-1:0]     incr,
    output logic                 busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    state_t               state, state_nxt;
    logic [DIV_WIDTH-1:0] pcnt, pcnt_nxt;
    logic [WIDTH-1:0]     target, target_nxt;
    logic [WIDTH-1:0]     incr_nxt, incr_step;
    logic                 tick;

    // One LSB toward the target; the bounds checks keep it from ever wrapping.
    function automatic logic [WIDTH-1:0] step_toward(input logic [WIDTH-1:0] cur,
                                                     input logic [WIDTH-1:0] tgt);
        if (tgt > cur)
            return cur + 1'b1;
        else if (tgt < cur)
            return cur - 1'b1;
        return cur;
    endfunction

    // The >= compare lets a shrinking div fire at once instead of wrapping pcnt.
    assign tick      = run && (pcnt >= div);
    assign incr_step = step_toward(incr, target);

    always_comb begin
        state_nxt  = state;
        incr_nxt   = incr;
        target_nxt = target;
        pcnt_nxt   = pcnt + 1'b1;
        if (!run || tick)
            pcnt_nxt = '0;

        case (state)
            IDLE: begin
                if (step_valid) begin
                    target_nxt = step_data;
                    if (step_data != incr)
                        state_nxt = RAMP;
                end
            end
            RAMP: begin
                if (tick) begin
                    incr_nxt = incr_step;
                    if (incr_step == target)
                        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            pcnt   <= '0;
            en     <= 1'b0;
            incr   <= WIDTH'(INIT_INCR);
            target <= WIDTH'(INIT_INCR);
        end else begin
            state  <= state_nxt;
            pcnt   <= pcnt_nxt;
            en     <= tick;
            incr   <= incr_nxt;
            target <= target_nxt;
        end
    end

    assign step_ready = (state == IDLE);
    assign busy       = (state == RAMP);

endmodule

// File: tb/tb_phase_step_ctrl.sv
// Directed bench for phase_step_ctrl: per-cycle vector table plus hand-written
// sequences for run stall, live div change and asynchronous reset mid-ramp.
module tb_phase_step_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [15:0] div;
    logic        step_valid;
    logic [8:0]  step_data;
    logic        step_ready;
    logic        en;
    logic [8:0]  incr;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    phase_step_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .div        (div),
        .step_valid (step_valid),
        .step_data  (step_data),
        .step_ready (step_ready),
        .en         (en),
        .incr       (incr),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       rst_n;
        bit       run;
        int       div;
        bit       sv;
        int       sd;
        bit       en;
        int       incr;
        bit       busy;
        bit       ready;
    } vec_t;

    vec_t vq[$];

    task automatic add(input bit r, input bit rn, input int dv, input bit sv, input int sd,
                       input bit e, input int inc, input bit b, input bit rdy);
        vec_t v;
        v.rst_n = r; v.run = rn; v.div = dv; v.sv = sv; v.sd = sd;
        v.en = e; v.incr = inc; v.busy = b; v.ready = rdy;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input bit e, input int inc, input bit b, input bit rdy);
        chk({tag, ".en"},    int'(en),         int'(e));
        chk({tag, ".incr"},  int'(incr),       inc);
        chk({tag, ".busy"},  int'(busy),       int'(b));
        chk({tag, ".ready"}, int'(step_ready), int'(rdy));
    endtask

    task automatic drive(input bit r, input bit rn, input int dv, input bit sv, input int sd);
        @(negedge clk);
        rst_n      = r;
        run        = rn;
        div        = 16'(dv);
        step_valid = sv;
        step_data  = 9'(sd);
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; run = 1'b0; div = '0; step_valid = 1'b0; step_data = '0;

        // Free-running strobe, div=3: en at edges 4 and 8.
        add(0,0,3,0,0, 0,1,0,1);
        for (int i = 1; i <= 8; i++)
            add(1,1,3,0,0, (i % 4 == 0), 1, 0, 1);

        // div=0 ramp 1 -> 4.
        add(0,0,0,0,0, 0,1,0,1);
        add(1,1,0,1,4, 1,1,1,0);
        add(1,1,0,0,0, 1,2,1,0);
        add(1,1,0,0,0, 1,3,1,0);
        add(1,1,0,0,0, 1,4,0,1);
        add(1,1,0,0,0, 1,4,0,1);
        // Up to 5, then div=2 ramp down to 2 with a second request held while busy.
        add(1,1,0,1,5, 1,4,1,0);
        add(1,1,0,0,0, 1,5,0,1);
        add(1,1,2,1,2, 0,5,1,0);
        add(1,1,2,1,9, 0,5,1,0);
        add(1,1,2,1,9, 1,4,1,0);
        add(1,1,2,1,9, 0,4,1,0);
        add(1,1,2,1,9, 0,4,1,0);
        add(1,1,2,1,9, 1,3,1,0);
        add(1,1,2,1,9, 0,3,1,0);
        add(1,1,2,1,9, 0,3,1,0);
        add(1,1,2,1,9, 1,2,0,1);
        add(1,1,2,1,9, 0,2,1,0);
        add(1,1,2,0,0, 0,2,1,0);
        add(1,1,2,0,0, 1,3,1,0);
        // Ramp to zero and hold there without wrapping.
        add(0,0,0,0,0, 0,1,0,1);
        add(1,1,0,1,0, 1,1,1,0);
        add(1,1,0,0,0, 1,0,0,1);
        add(1,1,0,0,0, 1,0,0,1);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst_n, vq[i].run, vq[i].div, vq[i].sv, vq[i].sd);
            edge_wait();
            chk_all($sformatf("vec%0d", i), vq[i].en, vq[i].incr, vq[i].busy, vq[i].ready);
        end

        // Stall: ramp 1 -> 6, run drops for 10 cycles at incr=3, then resumes.
        drive(0,0,0,0,0); edge_wait();
        drive(1,1,0,1,6); edge_wait();
        drive(1,1,0,0,0); edge_wait();
        edge_wait();
        chk_all("stall.pre", 1, 3, 1, 0);
        for (int i = 0; i < 10; i++) begin
            drive(1,0,0,0,0); edge_wait();
            chk_all($sformatf("stall%0d", i), 0, 3, 1, 0);
        end
        drive(1,1,0,0,0); edge_wait();
        chk_all("stall.resume", 1, 4, 1, 0);

        // Live div change 100 -> 2 with pcnt at 50.
        drive(0,0,100,0,0); edge_wait();
        for (int i = 0; i < 50; i++) begin
            drive(1,1,100,0,0); edge_wait();
            chk($sformatf("div100.en%0d", i), int'(en), 0);
        end
        for (int i = 0; i < 7; i++) begin
            drive(1,1,2,0,0); edge_wait();
            chk($sformatf("div2.en%0d", i), int'(en), (i % 3 == 0) ? 1 : 0);
        end

        // Asynchronous reset mid-ramp at incr=7, target=20.
        drive(0,0,0,0,0); edge_wait();
        drive(1,1,0,1,20); edge_wait();
        for (int i = 0; i < 6; i++) begin
            drive(1,1,0,0,0); edge_wait();
        end
        chk_all("prerst", 1, 7, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("asyncrst", 0, 1, 0, 1);
        drive(0,1,0,0,0); edge_wait();
        chk_all("rsthold", 0, 1, 0, 1);
        drive(1,1,0,1,1); edge_wait();
        chk_all("sameincr", 1, 1, 0, 1);
        drive(1,1,0,0,0); edge_wait();
        chk_all("sameincr2", 1, 1, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
